// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
//
// Owns the single write port of the 32x32 register file. Two writeback
// sources (ALU and load/MEM) compete for the port. The arbitration is
// round-robin with one priority bit. The winning write is driven to the
// register file from registers one cycle later.
//
// A busy-bit scoreboard tracks destination registers that still have a
// write in flight. The issue stage uses it to stall on RAW hazards.
//
// Handshake: a source holds `xxxValid` together with its address and data.
// A transfer happens in any cycle where valid && ready are both high.
// `xxxReady` never depends on the same source's own valid. At most one
// source transfers per cycle. Both readies are forced low while reset is
// high.
//
// Ports
//   clock, reset                    rising-edge clock, synchronous active-high reset
//   aluValid/aluReady/aluAdrs/aluData  ALU writeback request
//   memValid/memReady/memAdrs/memData  load writeback request
//   issueValid, issueAdrs           issue stage marks a destination as pending
//   issueBusy                       issueAdrs currently pending (combinational)
//   rs1Adrs/rs1Busy, rs2Adrs/rs2Busy   source operand pending lookups (combinational)
//   enable, rdAdrs, rdData          registered register-file write port

module regfile_write_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  aluValid,
    output logic                  aluReady,
    input  logic [ADDR_WIDTH-1:0] aluAdrs,
    input  logic [DATA_WIDTH-1:0] aluData,

    input  logic                  memValid,
    output logic                  memReady,
    input  logic [ADDR_WIDTH-1:0] memAdrs,
    input  logic [DATA_WIDTH-1:0] memData,

    input  logic                  issueValid,
    input  logic [ADDR_WIDTH-1:0] issueAdrs,
    output logic                  issueBusy,

    input  logic [ADDR_WIDTH-1:0] rs1Adrs,
    input  logic [ADDR_WIDTH-1:0] rs2Adrs,
    output logic                  rs1Busy,
    output logic                  rs2Busy,

    output logic                  enable,
    output logic [ADDR_WIDTH-1:0] rdAdrs,
    output logic [DATA_WIDTH-1:0] rdData
);

    localparam int NREGS = 1 << ADDR_WIDTH;

    // prio_q: 0 = MEM preferred, 1 = ALU preferred
    logic                  prio_q,      prio_d;
    logic                  enable_q,    enable_d;
    logic [ADDR_WIDTH-1:0] rd_adrs_q,   rd_adrs_d;
    logic [DATA_WIDTH-1:0] rd_data_q,   rd_data_d;
    logic [NREGS-1:0]      busy_q,      busy_d;

    logic                  alu_fire;
    logic                  mem_fire;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] win_adrs;
    logic [DATA_WIDTH-1:0] win_data;

    // A source is ready when the other one is idle, or when it holds priority.
    // Under contention exactly one of the two readies is high.
    assign aluReady = !reset && (!memValid || prio_q);
    assign memReady = !reset && (!aluValid || !prio_q);

    assign alu_fire = aluValid && aluReady;
    assign mem_fire = memValid && memReady;
    assign xfer     = alu_fire || mem_fire;

    assign win_adrs = mem_fire ? memAdrs : aluAdrs;
    assign win_data = mem_fire ? memData : aluData;

    always_comb begin
        prio_d    = prio_q;
        enable_d  = 1'b0;
        rd_adrs_d = rd_adrs_q;
        rd_data_d = rd_data_q;

        // After a transfer, the loser gets priority next time.
        if (alu_fire) begin
            prio_d = 1'b0;
        end else if (mem_fire) begin
            prio_d = 1'b1;
        end

        // A write to x0 still loads the address/data registers,
        // but it never raises enable.
        if (xfer) begin
            rd_adrs_d = win_adrs;
            rd_data_d = win_data;
            enable_d  = (win_adrs != '0);
        end
    end

    always_comb begin
        busy_d = busy_q;
        // The clear lands on the same edge as the register-file write.
        if (enable_q) begin
            busy_d[rd_adrs_q] = 1'b0;
        end
        // The set is applied after the clear. A newer producer issued in
        // the same cycle therefore keeps its bit.
        if (issueValid && (issueAdrs != '0)) begin
            busy_d[issueAdrs] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prio_q    <= 1'b0;
            enable_q  <= 1'b0;
            rd_adrs_q <= '0;
            rd_data_q <= '0;
            busy_q    <= '0;
        end else begin
            prio_q    <= prio_d;
            enable_q  <= enable_d;
            rd_adrs_q <= rd_adrs_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
        end
    end

    assign enable    = enable_q;
    assign rdAdrs    = rd_adrs_q;
    assign rdData    = rd_data_q;

    assign issueBusy = busy_q[issueAdrs];
    assign rs1Busy   = busy_q[rs1Adrs];
    assign rs2Busy   = busy_q[rs2Adrs];

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Write-port scheduler and scoreboard for the RISC-V 32×32 register file. Arbitrates the single register-file write port between the ALU writeback and load writeback paths with valid/ready handshakes. Drives the register file's `enable`/`rdAdrs`/`rdData` inputs from registers. Tracks pending destination registers so the issue stage can stall on RAW hazards.

## Interface
Parameters:
- `DATA_WIDTH`, 32: register data width.
- `ADDR_WIDTH`, 5: register address width (32 registers).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `aluValid` in 1: ALU writeback request.
- `aluReady` out 1: ALU request accepted this cycle.
- `aluAdrs` in ADDR_WIDTH: ALU destination register.
- `aluData` in DATA_WIDTH: ALU result.
- `memValid`, `memReady`, `memAdrs`, `memData`: same as the ALU ports, for the load path.
- `issueValid` in 1: issue stage dispatches an instruction that writes a register.
- `issueAdrs` in ADDR_WIDTH: destination of the issued instruction.
- `issueBusy` out 1: `issueAdrs` currently pending (combinational).
- `rs1Adrs`, `rs2Adrs` in ADDR_WIDTH: source addresses being read by the issue stage.
- `rs1Busy`, `rs2Busy` out 1: corresponding source pending (combinational).
- `enable` out 1: register file write enable (registered).
- `rdAdrs` out ADDR_WIDTH: register file write address (registered).
- `rdData` out DATA_WIDTH: register file write data (registered).

## Operation
**State**
- `busy[31:0]` scoreboard.
- `prio` bit: 0 = MEM preferred, 1 = ALU preferred.
- Output registers `enable`, `rdAdrs`, `rdData`.

**Arbitration**
- `aluReady = !reset && (!memValid || prio==1)`.
- `memReady = !reset && (!aluValid || prio==0)`.
- Ready does not depend on the requester's own valid.
- A transfer occurs on valid && ready. At most one transfer per cycle.
- After every transfer, `prio` points to the non-winning source.
- With no transfer, `prio` is unchanged.

**Write issue**
- On a transfer, the next edge loads `rdAdrs`/`rdData` with the winner's address and data.
- `enable` is set to 1 unless the address is 0.
- A write to x0 completes the handshake, but `enable` = 0 and the scoreboard is untouched.
- With no transfer, `enable` is 0. `rdAdrs`/`rdData` hold their values.

**Scoreboard**
- Set: on `issueValid` with `issueAdrs != 0`, `busy[issueAdrs]` is set at the edge.
- Clear: at an edge where `enable == 1`, `busy[rdAdrs]` is cleared. This is the same edge at which the register file captures the write.
- Set and clear of the same address in the same cycle: set wins (a newer producer is in flight).
- `busy[0]` is always 0.
- `rs1Busy`, `rs2Busy` and `issueBusy` are read combinationally from `busy`.
- `issueValid` while `issueBusy == 1` (WAW) is a protocol violation and is not supported. The bit simply stays set.

**Reset** (synchronous)
- `enable` = 0, `rdAdrs` = 0, `rdData` = 0, `busy` = 0, `prio` = 0 (MEM first).
- `aluReady` = `memReady` = 0 while reset is high.
- Reset mid-operation discards any registered write: `enable` is 0 on the following cycle and all busy bits are cleared.

## Timing
- Handshake in cycle N → `enable`/`rdAdrs`/`rdData` valid in cycle N+1.
- Register file write lands at the end of cycle N+1.
- The busy bit reads 0 from cycle N+2. A register-file read of that address returns the new value from N+2.
- Issue in cycle N → busy bit reads 1 from cycle N+1.
- Throughput is one write per cycle. Two contending sources alternate every cycle.
- A lone requester is never stalled.

## Test plan
- **Single ALU write:** after reset, `aluValid`=1, `aluAdrs`=1, `aluData`=20 in cycle 0 → `aluReady`=1 in cycle 0; `enable`=1, `rdAdrs`=1, `rdData`=20 in cycle 1; `enable`=0 in cycle 2.
- **Contention:** both valid continuously, ALU (x2, 286) and MEM (x4, 1024), directly after reset → MEM wins cycle 0, ALU wins cycle 1, MEM wins cycle 2. The `enable` stream shows x4, x2, x4 in cycles 1–3.
- **x0 write:** `memValid`=1, `memAdrs`=0, `memData`=12 → `memReady`=1, `enable` stays 0, `busy` unchanged.
- **Scoreboard:**
  - `issueValid` with `issueAdrs`=5 in cycle 0 → `rs1Busy`=1 (`rs1Adrs`=5) from cycle 1.
  - MEM writes x5=12 in cycle 3 → `rs1Busy` stays 1 in cycle 4 (`enable`=1) and is 0 in cycle 5.
- **Simultaneous set/clear:** `issueAdrs`=5 issued in the same cycle that `enable`=1 with `rdAdrs`=5 → `busy[5]` remains 1 on the next cycle.
- **Reset mid-operation:** ALU handshake (x3, 7) in cycle 0, `reset`=1 in cycle 1 with `busy[3]` and `busy[6]` set → `enable`=0 in cycle 2, all busy bits 0, `aluReady`=0 during reset.
